// File: rtl/fifo_rd_checker_pkg.sv
// rtl/fifo_rd_checker_pkg.sv - shared FIFO geometry and read-checker state encoding
package definitions;
    localparam int DSIZE = 8;
    localparam int ASIZE = 4;

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} rd_chk_state_t;
endpackage

// File: rtl/fifo_rd_checker_if.sv
// rtl/fifo_rd_checker_if.sv - FIFO read-port bundle (rempty/rdata/rinc)
interface fifo_rd_checker_if #(
    parameter int DSIZE = definitions::DSIZE
);
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    logic             rinc;

    // master is the reader that pops; slave is the FIFO read port
    modport master (input rempty, input rdata, output rinc);
    modport slave  (output rempty, output rdata, input rinc);
endinterface

// File: rtl/fifo_rd_checker_pattern_gen.sv
// rtl/fifo_rd_checker_pattern_gen.sv - expected-value register for the incrementing reference sequence
module fifo_rd_pattern_gen #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             clear,
    input  logic             advance,
    output logic [DSIZE-1:0] exp
);
    import definitions::*;

    localparam logic [DSIZE-1:0] EXP_ONE = DSIZE'(1);

    logic [DSIZE-1:0] exp_q;
    logic [DSIZE-1:0] exp_d;

    always_comb begin
        exp_d = exp_q;
        if (clear) begin
            exp_d = '0;
        end else if (advance) begin
            exp_d = exp_q + EXP_ONE;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            exp_q <= '0;
        end else begin
            exp_q <= exp_d;
        end
    end

    assign exp = exp_q;
endmodule

// File: rtl/fifo_rd_checker.sv
// rtl/fifo_rd_checker.sv - read-side FIFO consumer/checker with burst/gap pacing and error capture
// Optional stall timeout: FIFO_RD_CHK_TIMEOUT_EN
module fifo_rd_checker #(
    parameter int DSIZE          = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_words,
    input  logic [7:0]           burst_len,
    input  logic [7:0]           gap_cycles,
    fifo_rd_checker_if.master    fifo,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 err_seen,
    output logic [DSIZE-1:0]     first_err_data,
    output logic [DSIZE-1:0]     first_err_exp
`ifdef FIFO_RD_CHK_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);
    import definitions::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    rd_chk_state_t    state_q, state_d;
    logic [CNT_W-1:0] num_words_q, num_words_d;
    logic [7:0]       burst_len_q, burst_len_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_seen_q, err_seen_d;
    logic [DSIZE-1:0] first_err_data_q, first_err_data_d;
    logic [DSIZE-1:0] first_err_exp_q, first_err_exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             exp_clear;
    logic [DSIZE-1:0] exp_val;

`ifdef FIFO_RD_CHK_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    // Pop is gated by reset so nothing is consumed from the FIFO in the reset cycle itself
    assign accept    = !rrst && (state_q == BURST) && !fifo.rempty;
    assign fifo.rinc = accept;

    fifo_rd_pattern_gen #(.DSIZE(DSIZE)) u_pattern (
        .rclk    (rclk),
        .rrst    (rrst),
        .clear   (exp_clear),
        .advance (accept),
        .exp     (exp_val)
    );

    always_comb begin
        state_d          = state_q;
        num_words_d      = num_words_q;
        burst_len_d      = burst_len_q;
        gap_d            = gap_q;
        burst_cnt_d      = burst_cnt_q;
        gap_cnt_d        = gap_cnt_q;
        rd_count_d       = rd_count_q;
        err_count_d      = err_count_q;
        err_seen_d       = err_seen_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        exp_clear        = 1'b0;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
        stall_d          = stall_q;
        timeout_d        = timeout_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_words_d      = num_words;
                    burst_len_d      = (burst_len == 8'd0) ? 8'd1 : burst_len;
                    gap_d            = gap_cycles;
                    burst_cnt_d      = '0;
                    gap_cnt_d        = '0;
                    rd_count_d       = '0;
                    err_count_d      = '0;
                    err_seen_d       = 1'b0;
                    first_err_data_d = '0;
                    first_err_exp_d  = '0;
                    exp_clear        = 1'b1;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
                    stall_d          = '0;
                    timeout_d        = 1'b0;
`endif
                    state_d = (num_words == '0) ? DONE : BURST;
                end
            end

            BURST: begin
                if (accept) begin
                    rd_count_d = rd_count_q + CNT_ONE;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
                    stall_d    = '0;
`endif
                    if (fifo.rdata != exp_val) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_ONE;
                        end
                        err_seen_d = 1'b1;
                        if (!err_seen_q) begin
                            first_err_data_d = fifo.rdata;
                            first_err_exp_d  = exp_val;
                        end
                    end
                    // Run completion wins over the end-of-burst decision
                    if (rd_count_q == num_words_q - CNT_ONE) begin
                        state_d     = DONE;
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q == burst_len_q - 8'd1) begin
                        burst_cnt_d = '0;
                        if (gap_q != 8'd0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end
`ifdef FIFO_RD_CHK_TIMEOUT_EN
                else if (!rrst) begin
                    if (stall_q == STALL_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                        stall_d   = '0;
                    end else begin
                        stall_d = stall_q + STALL_ONE;
                    end
                end
`endif
            end

            GAP: begin
                if (gap_cnt_q == gap_q - 8'd1) begin
                    gap_cnt_d = '0;
                    state_d   = BURST;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == BURST) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q          <= IDLE;
            num_words_q      <= '0;
            burst_len_q      <= '0;
            gap_q            <= '0;
            burst_cnt_q      <= '0;
            gap_cnt_q        <= '0;
            rd_count_q       <= '0;
            err_count_q      <= '0;
            err_seen_q       <= 1'b0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
            stall_q          <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            num_words_q      <= num_words_d;
            burst_len_q      <= burst_len_d;
            gap_q            <= gap_d;
            burst_cnt_q      <= burst_cnt_d;
            gap_cnt_q        <= gap_cnt_d;
            rd_count_q       <= rd_count_d;
            err_count_q      <= err_count_d;
            err_seen_q       <= err_seen_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
            stall_q          <= stall_d;
            timeout_q        <= timeout_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign rd_count       = rd_count_q;
    assign err_count      = err_count_q;
    assign err_seen       = err_seen_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
`ifdef FIFO_RD_CHK_TIMEOUT_EN
    assign timeout        = timeout_q;
`endif
endmodule
